// File: rtl/exec_stage_mc_pkg.sv
// params_proc: shared opcode encodings, control width and execute-stage
// FSM state encoding for the processor execute stage.
//
// No ports (package). Imported by exec_stage_mc and its testbench.
package params_proc;

  localparam int CTRL_WIDTH = 4;

  localparam logic [CTRL_WIDTH-1:0] OP_LW   = 4'd0;
  localparam logic [CTRL_WIDTH-1:0] OP_SW   = 4'd1;
  localparam logic [CTRL_WIDTH-1:0] OP_ADD  = 4'd2;
  localparam logic [CTRL_WIDTH-1:0] OP_SUB  = 4'd3;
  localparam logic [CTRL_WIDTH-1:0] OP_AND  = 4'd4;
  localparam logic [CTRL_WIDTH-1:0] OP_OR   = 4'd5;
  localparam logic [CTRL_WIDTH-1:0] OP_NOT  = 4'd6;
  localparam logic [CTRL_WIDTH-1:0] OP_CMP  = 4'd7;
  localparam logic [CTRL_WIDTH-1:0] OP_JR   = 4'd8;
  localparam logic [CTRL_WIDTH-1:0] OP_JPC  = 4'd9;
  localparam logic [CTRL_WIDTH-1:0] OP_RET  = 4'd10;
  localparam logic [CTRL_WIDTH-1:0] OP_CALL = 4'd11;
  localparam logic [CTRL_WIDTH-1:0] OP_BRFL = 4'd12;
  localparam logic [CTRL_WIDTH-1:0] OP_MUL  = 4'd13;
  localparam logic [CTRL_WIDTH-1:0] OP_DIV  = 4'd14;
  localparam logic [CTRL_WIDTH-1:0] OP_NOP  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [CTRL_WIDTH-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/exec_muldiv.sv
// exec_muldiv: iterative multiply / divide unit, one bit per clock.
//   MUL: shift-add on the raw two's-complement operands; the low WIDTH bits
//        of that product equal the low bits of the signed product.
//   DIV: restoring divide on operand magnitudes, sign applied at the end,
//        quotient truncated toward zero; divide by zero yields all ones.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (aborts operation)
//   start, is_div     launch an operation (MUL when is_div = 0)
//   a, b              operands (signed two's complement)
//   busy              operation in flight
//   done              high in the last busy cycle; result/div0 valid then
//   result, div0      result and divide-by-zero indication
module exec_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  // opa: multiplier (MUL) or dividend shifting out / quotient shifting in (DIV)
  logic [WIDTH-1:0] opa_q, opa_d;
  // opb: multiplicand (MUL) or divisor magnitude (DIV)
  logic [WIDTH-1:0] opb_q, opb_d;
  // acc: running product (MUL) or partial remainder (DIV)
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   shifted;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    shifted  = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(WIDTH);
      is_div_d = is_div;
      neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
      zero_d   = (b == '0);
      acc_d    = '0;
      opa_d    = is_div ? magnitude(a) : a;
      opb_d    = is_div ? magnitude(b) : b;
    end else if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
      if (is_div_q) begin
        if (shifted >= {1'b0, opb_q}) begin
          acc_d = shifted - {1'b0, opb_q};
          opa_d = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted;
          opa_d = {opa_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (opa_q[0]) begin
          acc_d = {1'b0, acc_q[WIDTH-1:0] + opb_q};
        end
        opa_d = opa_q >> 1;
        opb_d = opb_q << 1;
      end
    end
  end

  // The result is taken from the next-state values so the final iteration
  // and the hand-off to the stage happen on the same clock edge.
  always_comb begin
    result = acc_d[WIDTH-1:0];
    if (is_div_q) begin
      if (zero_q) begin
        result = '1;
      end else begin
        result = neg_q ? -opa_d : opa_d;
      end
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign div0 = done && is_div_q && zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/exec_stage_mc.sv
// exec_stage_mc: processor execute stage with valid/ready handshakes on both
// sides. Single-cycle ops produce a registered result one cycle after accept;
// MUL/DIV run in exec_muldiv and take DATA_WIDTH+1 cycles.
//
// Configuration macro: EXEC_MULDIV_EN
//   defined   -> exec_muldiv instantiated, multi-cycle MUL/DIV
//   undefined -> MUL/DIV complete in one cycle with data = 0, div0 = 0
//
// Ports:
//   clk_in, RST            clock, synchronous active-high reset
//   valid_in / ready_out   upstream handshake
//   ctrl_in, pc_in         opcode and instruction PC
//   A_addr, B_addr         source register indices
//   A, B, imm              signed operands and immediate
//   valid_out / ready_in   downstream handshake
//   pc_chg, pc_out         fetch redirect and target
//   data, addr, reg_addr   result/store data, memory address, destination
//   ctrl_out               forwarded opcode
//   done                   valid_out && ready_in
//   div0                   DIV by zero, registered with the result
module exec_stage_mc
  import params_proc::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int PC_WIDTH       = 16,
  parameter int MEM_WIDTH      = 16,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                         clk_in,
  input  logic                         RST,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [CTRL_WIDTH-1:0]        ctrl_in,
  input  logic [PC_WIDTH-1:0]          pc_in,
  input  logic [REG_ADDR_WIDTH-1:0]    A_addr,
  input  logic [REG_ADDR_WIDTH-1:0]    B_addr,
  input  logic signed [DATA_WIDTH-1:0] A,
  input  logic signed [DATA_WIDTH-1:0] B,
  input  logic signed [DATA_WIDTH-1:0] imm,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         pc_chg,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic [DATA_WIDTH-1:0]        data,
  output logic [MEM_WIDTH-1:0]         addr,
  output logic [REG_ADDR_WIDTH-1:0]    reg_addr,
  output logic [CTRL_WIDTH-1:0]        ctrl_out,
  output logic                         done,
  output logic                         div0
);

  state_e                      state_q, state_d;
  logic                        z_q, z_d, lt_q, lt_d;
  logic                        pc_chg_q, pc_chg_d;
  logic                        div0_q, div0_d;
  logic [PC_WIDTH-1:0]         pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic [MEM_WIDTH-1:0]        addr_q, addr_d;
  logic [REG_ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
  logic [CTRL_WIDTH-1:0]       ctrl_q, ctrl_d;

  logic                        accept;
  logic                        flag_sel;
  logic [DATA_WIDTH-1:0]       eff_addr;
  logic                        mdu_busy, mdu_done, mdu_div0;
  logic [DATA_WIDTH-1:0]       mdu_result;

`ifdef EXEC_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
  logic mdu_start;

  assign mdu_start = accept && is_muldiv(ctrl_in);

  exec_muldiv #(
    .WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clk    (clk_in),
    .rst    (RST),
    .start  (mdu_start),
    .is_div (ctrl_in == OP_DIV),
    .a      (A),
    .b      (B),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .result (mdu_result),
    .div0   (mdu_div0)
  );
`else
  localparam bit MULDIV_EN = 1'b0;

  assign mdu_busy   = 1'b0;
  assign mdu_done   = 1'b0;
  assign mdu_result = '0;
  assign mdu_div0   = 1'b0;
`endif

  // Reset forces ready_out low combinationally so nothing is accepted in the
  // reset cycle; the mdu_busy term keeps a running unit from being restarted.
  assign ready_out = !RST && !mdu_busy &&
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && ready_in));
  assign accept    = valid_in && ready_out;
  assign eff_addr  = A + imm;
  // BRFL reads the registered flags, so a CMP accepted on the previous edge
  // is already visible.
  assign flag_sel  = imm[0] ? lt_q : z_q;

  always_comb begin
    state_d    = state_q;
    z_d        = z_q;
    lt_d       = lt_q;
    pc_chg_d   = pc_chg_q;
    pc_out_d   = pc_out_q;
    data_d     = data_q;
    addr_d     = addr_q;
    reg_addr_d = reg_addr_q;
    ctrl_d     = ctrl_q;
    div0_d     = div0_q;

    case (state_q)
      ST_BUSY: begin
        if (mdu_done) begin
          data_d  = mdu_result;
          div0_d  = mdu_div0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ready_in) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    // A new accept overrides the HOLD->IDLE move above.
    if (accept) begin
      state_d    = ST_HOLD;
      ctrl_d     = ctrl_in;
      pc_chg_d   = 1'b0;
      pc_out_d   = '0;
      data_d     = '0;
      addr_d     = '0;
      reg_addr_d = '0;
      div0_d     = 1'b0;
      case (ctrl_in)
        OP_LW: begin
          addr_d     = MEM_WIDTH'(eff_addr);
          reg_addr_d = B_addr;
        end
        OP_SW: begin
          addr_d = MEM_WIDTH'(eff_addr);
          data_d = B;
        end
        OP_ADD: begin data_d = A + B;  reg_addr_d = A_addr; end
        OP_SUB: begin data_d = A - B;  reg_addr_d = A_addr; end
        OP_AND: begin data_d = A & B;  reg_addr_d = A_addr; end
        OP_OR:  begin data_d = A | B;  reg_addr_d = A_addr; end
        OP_NOT: begin data_d = ~A;     reg_addr_d = A_addr; end
        OP_CMP: begin
          z_d  = (A == B);
          lt_d = (A < B);
        end
        OP_JR, OP_RET: begin
          pc_chg_d = 1'b1;
          pc_out_d = PC_WIDTH'(A);
        end
        OP_JPC: begin
          pc_chg_d = 1'b1;
          pc_out_d = pc_in + PC_WIDTH'(imm);
        end
        OP_CALL: begin
          pc_chg_d   = 1'b1;
          pc_out_d   = PC_WIDTH'(A);
          data_d     = DATA_WIDTH'(pc_in + PC_WIDTH'(1));
          reg_addr_d = A_addr;
        end
        OP_BRFL: begin
          if (flag_sel == B[0]) begin
            pc_chg_d = 1'b1;
            pc_out_d = PC_WIDTH'(A);
          end
        end
        OP_MUL, OP_DIV: begin
          reg_addr_d = A_addr;
          if (MULDIV_EN) begin
            state_d = ST_BUSY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      z_q        <= 1'b0;
      lt_q       <= 1'b0;
      pc_chg_q   <= 1'b0;
      pc_out_q   <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      reg_addr_q <= '0;
      ctrl_q     <= '0;
      div0_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      z_q        <= z_d;
      lt_q       <= lt_d;
      pc_chg_q   <= pc_chg_d;
      pc_out_q   <= pc_out_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      reg_addr_q <= reg_addr_d;
      ctrl_q     <= ctrl_d;
      div0_q     <= div0_d;
    end
  end

  assign valid_out = (state_q == ST_HOLD);
  assign done      = valid_out && ready_in;
  assign pc_chg    = pc_chg_q;
  assign pc_out    = pc_out_q;
  assign data      = data_q;
  assign addr      = addr_q;
  assign reg_addr  = reg_addr_q;
  assign ctrl_out  = ctrl_q;
  assign div0      = div0_q;

endmodule
